pll_lock_supervisor: RTL



---
 rtl/pll_sup_pkg.sv | 17 +
 rtl/sync_bit.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and counter sizing.
package pll_sup_pkg;

  typedef enum logic [2:0] {PRST, WAIT, STABLE, REL, RUN, FAIL} state_t;

  // Width able to hold the largest count any phase of the sequence needs.
  function automatic int cnt_width(input int timeout, input int stable,
                                   input int release_span, input int rst_cycles);
    int m;
    m = timeout;
    if (stable > m)       m = stable;
    if (release_span > m) m = release_span;
    if (rst_cycles > m)   m = rst_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-stage synchroniser for a single asynchronous status bit, cleared by reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Pulses the PLL reset, qualifies lock stability, then releases core resets in a staggered order.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 74250,
  parameter int LOCK_STABLE    = 1024,
  parameter int NUM_DOMAINS    = 3,
  parameter int STAGGER        = 8,
  parameter int MAX_RETRIES    = 4
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   fail,
  output logic [2:0]             retry_count,
  output logic                   lock_lost
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, LOCK_STABLE, NUM_DOMAINS * STAGGER, PLL_RST_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] REL_LAST = CW'((NUM_DOMAINS - 1) * STAGGER);
  localparam logic [2:0]    MAX_R    = 3'(MAX_RETRIES);

  logic lk;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;     // phase counter: PRST width, STABLE run, REL offset
  logic [CW-1:0]          tcnt_q, tcnt_d;   // lock timeout, armed across WAIT and STABLE
  logic [2:0]             retry_d;
  logic                   pll_rst_d, ready_d, fail_d, lost_d, restart;
  logic [NUM_DOMAINS-1:0] dom_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    retry_d   = retry_count;
    pll_rst_d = pll_rst;
    dom_d     = domain_rst;
    ready_d   = ready;
    fail_d    = fail;
    lost_d    = 1'b0;
    restart   = 1'b0;

    case (state_q)
      PRST: begin
        if (cnt_q == '0 && retry_count != MAX_R) retry_d = retry_count + 3'd1;
        if (cnt_q == RST_LAST) begin
          state_d   = WAIT;
          cnt_d     = '0;
          tcnt_d    = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      WAIT: begin
        if (tcnt_q != TO_LAST) tcnt_d = tcnt_q + ONE;
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (tcnt_q == TO_LAST) begin
          restart = 1'b1;
        end
      end
      STABLE: begin
        if (tcnt_q != TO_LAST) tcnt_d = tcnt_q + ONE;
        if (lk && cnt_q == STB_LAST) begin
          state_d  = REL;
          cnt_d    = '0;
          dom_d[0] = 1'b0;
        end else begin
          cnt_d = lk ? cnt_q + ONE : '0;
          if (tcnt_q == TO_LAST) restart = 1'b1;
        end
      end
      REL: begin
        if (!lk) begin
          restart = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
          for (int i = 1; i < NUM_DOMAINS; i++)
            if (cnt_q + ONE == CW'(i * STAGGER)) dom_d[i] = 1'b0;
        end
      end
      RUN: begin
        if (!lk) begin
          lost_d  = 1'b1;
          restart = 1'b1;
        end
      end
      default: ;
    endcase

    // Timeout or loss of lock: reassert everything, then retry or give up.
    if (restart) begin
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      dom_d     = '1;
      ready_d   = 1'b0;
      if (retry_count == MAX_R) begin
        state_d = FAIL;
        fail_d  = 1'b1;
      end else begin
        state_d = PRST;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= PRST;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      domain_rst  <= '1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      retry_count <= retry_d;
      pll_rst     <= pll_rst_d;
      domain_rst  <= dom_d;
      ready       <= ready_d;
      fail        <= fail_d;
      lock_lost   <= lost_d;
    end
  end

endmodule
